// File: rtl/ddr4_axi_pkg.sv
// Shared AXI4 constants and helpers for the DDR4 state reader/writer.
// Lane layout: eight 64-bit words per 512-bit beat, lane 0 in [63:0].
package ddr4_axi_pkg;

  localparam int LANES_PER_BEAT = 8;
  localparam int BYTES_PER_BEAT = 64;
  localparam int WORD_W = BYTES_PER_BEAT * 8 / LANES_PER_BEAT;

  localparam logic [2:0] AXSIZE_64B = 3'b110;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int ceil_div(
    input int num,
    input int den
  );
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ddr4_state_reader.sv
// AXI4 read master: loads Kalman X then P (row-major) from DDR4.
// Ports: clk/rst_n, read_en start, X/P arrays, status, AXI AR/R.
module ddr4_state_reader
  import ddr4_axi_pkg::*;
#(
  parameter int          STATE_DIM   = 12,
  parameter logic [31:0] ADDR_X_BASE = 32'h0010_0000,
  parameter logic [31:0] ADDR_P_BASE = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_en,
  output logic [STATE_DIM-1:0][WORD_W-1:0] X_kk_out,
  output logic [STATE_DIM-1:0][STATE_DIM-1:0][WORD_W-1:0] P_kk_out,
  output logic        data_valid,
  output logic        busy,
  output logic        rd_error,
  output logic [31:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [511:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  localparam int X_BEATS =
    ceil_div(STATE_DIM, LANES_PER_BEAT);
  localparam int P_BEATS =
    ceil_div(STATE_DIM * STATE_DIM, LANES_PER_BEAT);
  localparam logic [7:0] X_ARLEN = 8'(X_BEATS - 1);
  localparam logic [7:0] P_ARLEN = 8'(P_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    AR_X,
    R_X,
    AR_P,
    R_P,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0] beat;
  logic ar_hs;
  logic r_hs;
  logic last_beat;
  logic burst_end;
  logic resp_bad;
  logic len_bad;

  assign ar_hs     = axi_arvalid & axi_arready;
  assign r_hs      = axi_rvalid & axi_rready;
  assign last_beat = (beat == axi_arlen);
  // rlast and the beat count may disagree; either one ends the burst.
  assign burst_end = r_hs & (axi_rlast | last_beat);
  assign resp_bad  = (axi_rresp != RESP_OKAY);
  assign len_bad   = axi_rlast ^ last_beat;

  assign axi_arsize  = AXSIZE_64B;
  assign axi_arburst = BURST_INCR;
  assign data_valid  = (state == DONE);
  assign busy        = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (read_en)   state_nxt = AR_X;
      AR_X: if (ar_hs)     state_nxt = R_X;
      R_X:  if (burst_end) state_nxt = AR_P;
      AR_P: if (ar_hs)     state_nxt = R_P;
      R_P:  if (burst_end) state_nxt = DONE;
      DONE: if (!read_en)  state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      beat        <= '0;
      rd_error    <= 1'b0;
    end else begin
      if (state == IDLE && read_en) begin
        axi_araddr  <= ADDR_X_BASE;
        axi_arlen   <= X_ARLEN;
        axi_arvalid <= 1'b1;
        beat        <= '0;
        rd_error    <= 1'b0;
      end
      if (ar_hs) begin
        axi_arvalid <= 1'b0;
        axi_rready  <= 1'b1;
        beat        <= '0;
      end
      if (r_hs) begin
        if (resp_bad || len_bad) rd_error <= 1'b1;
        if (burst_end) begin
          axi_rready <= 1'b0;
          // P address goes out on the same edge as the last X beat.
          if (state == R_X) begin
            axi_araddr  <= ADDR_P_BASE;
            axi_arlen   <= P_ARLEN;
            axi_arvalid <= 1'b1;
          end
        end else begin
          beat <= beat + 8'd1;
        end
      end
    end
  end

  // Each destination word picks its lane when its beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      X_kk_out <= '0;
      P_kk_out <= '0;
    end else if (r_hs && state == R_X) begin
      for (int i = 0; i < STATE_DIM; i++) begin
        if (beat == 8'(i / LANES_PER_BEAT))
          X_kk_out[i] <=
            axi_rdata[(i % LANES_PER_BEAT) * WORD_W +: WORD_W];
      end
    end else if (r_hs && state == R_P) begin
      for (int r = 0; r < STATE_DIM; r++) begin
        for (int c = 0; c < STATE_DIM; c++) begin
          if (beat == 8'((r * STATE_DIM + c) / LANES_PER_BEAT))
            P_kk_out[r][c] <= axi_rdata[
              ((r * STATE_DIM + c) % LANES_PER_BEAT) * WORD_W
              +: WORD_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr4_state_reader.sv
// Bench for ddr4_state_reader: AXI slave + memory reference model.
// Covers latency, backpressure, rresp/rlast faults, reset, dim 4.
module tb_ddr4_state_reader;

  localparam int SD  = 12;
  localparam int SD4 = 4;
  localparam logic [31:0] XB = 32'h0010_0000;
  localparam logic [31:0] PB = 32'h0020_0000;
  localparam int XBEATS = (SD + 7) / 8;
  localparam int PBEATS = (SD * SD + 7) / 8;
  localparam int XW = XBEATS * 8;
  localparam int PW = PBEATS * 8;

  logic clk;
  logic rst_n;
  logic read_en;
  logic [SD-1:0][63:0] X_kk_out;
  logic [SD-1:0][SD-1:0][63:0] P_kk_out;
  logic data_valid, busy, rd_error;
  logic [31:0] axi_araddr;
  logic [7:0] axi_arlen;
  logic [2:0] axi_arsize;
  logic [1:0] axi_arburst;
  logic axi_arvalid, axi_arready;
  logic [511:0] axi_rdata;
  logic [1:0] axi_rresp;
  logic axi_rlast, axi_rvalid, axi_rready;

  logic read_en4;
  logic [SD4-1:0][63:0] x4;
  logic [SD4-1:0][SD4-1:0][63:0] p4;
  logic dv4, busy4, err4;
  logic [31:0] araddr4;
  logic [7:0] arlen4;
  logic [2:0] arsize4;
  logic [1:0] arburst4;
  logic arvalid4, arready4;
  logic [511:0] rdata4;
  logic [1:0] rresp4;
  logic rlast4, rvalid4, rready4;

  int n_pass, n_total, n_fail;

  logic [63:0] mem_x [XW];
  logic [63:0] mem_p [PW];
  logic [63:0] exp_x [SD];
  logic [63:0] exp_p [SD*SD];
  logic [31:0] log_a [$];
  int          log_l [$];
  logic [31:0] log4_a [$];
  int          log4_l [$];

  ddr4_state_reader #(.STATE_DIM(SD)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en),
    .X_kk_out(X_kk_out), .P_kk_out(P_kk_out),
    .data_valid(data_valid), .busy(busy), .rd_error(rd_error),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready)
  );

  ddr4_state_reader #(.STATE_DIM(SD4)) dut4 (
    .clk(clk), .rst_n(rst_n), .read_en(read_en4),
    .X_kk_out(x4), .P_kk_out(p4),
    .data_valid(dv4), .busy(busy4), .rd_error(err4),
    .axi_araddr(araddr4), .axi_arlen(arlen4),
    .axi_arsize(arsize4), .axi_arburst(arburst4),
    .axi_arvalid(arvalid4), .axi_arready(arready4),
    .axi_rdata(rdata4), .axi_rresp(rresp4),
    .axi_rlast(rlast4), .axi_rvalid(rvalid4),
    .axi_rready(rready4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_total++;
    if (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < XW; i++)
      mem_x[i] = (i < SD) ? 64'h100 + 64'(i)
                          : 64'hBAD0_0000_0000_0000 | 64'(i);
    for (int i = 0; i < PW; i++)
      mem_p[i] = (i < SD*SD) ? 64'h1000 + 64'(i)
                             : 64'hBAD1_0000_0000_0000 | 64'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < XW; i++) mem_x[i] = {$urandom, $urandom};
    for (int i = 0; i < PW; i++) mem_p[i] = {$urandom, $urandom};
  endtask

  task automatic model_clear();
    for (int i = 0; i < SD; i++) exp_x[i] = '0;
    for (int i = 0; i < SD*SD; i++) exp_p[i] = '0;
  endtask

  task automatic model_load(input int limit);
    for (int i = 0; i < SD; i++) exp_x[i] = mem_x[i];
    for (int i = 0; i < SD*SD; i++)
      if (i < limit) exp_p[i] = mem_p[i];
  endtask

  task automatic check_arrays(input string tag);
    int bx, bp;
    bx = 0;
    bp = 0;
    for (int i = 0; i < SD; i++)
      if (X_kk_out[i] !== exp_x[i]) bx++;
    for (int r = 0; r < SD; r++)
      for (int c = 0; c < SD; c++)
        if (P_kk_out[r][c] !== exp_p[r*SD+c]) bp++;
    chk({tag, "_x_bad_words"}, bx, 0);
    chk({tag, "_p_bad_words"}, bp, 0);
  endtask

  task automatic run_read(
    input  bit bp,
    input  int err_beat,
    input  int early_beat,
    input  int rst_beat,
    output int cyc,
    output bit err_done
  );
    logic [31:0] qa [$];
    int ql [$];
    int rb;
    bit done, aborted, isp, arp, rp, lastc, wait_ar;
    logic [31:0] ca, wa;
    logic [7:0] cl, wl;
    int w;
    rb = 0;
    done = 0;
    aborted = 0;
    wait_ar = 0;
    err_done = 0;
    cyc = 1;
    read_en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (wait_ar) begin
        chk("arvalid_held", axi_arvalid, 1'b1);
        chk("araddr_held", axi_araddr, wa);
        chk("arlen_held", axi_arlen, wl);
      end
      axi_arready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (qa.size() > 0) begin
        isp = (qa[0] == PB);
        for (int l = 0; l < 8; l++) begin
          w = rb * 8 + l;
          if (isp) axi_rdata[l*64 +: 64] = (w < PW) ? mem_p[w] : '0;
          else     axi_rdata[l*64 +: 64] = (w < XW) ? mem_x[w] : '0;
        end
        axi_rlast  = (rb == ql[0]) || (isp && rb == early_beat);
        axi_rresp  = (isp && rb == err_beat) ? 2'b10 : 2'b00;
        axi_rvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (isp && rb == rst_beat && axi_rready) begin
          rst_n = 1'b0;
          #1;
          chk("rst_data_valid", data_valid, 1'b0);
          chk("rst_busy", busy, 1'b0);
          chk("rst_arvalid", axi_arvalid, 1'b0);
          chk("rst_rready", axi_rready, 1'b0);
          chk("rst_araddr", axi_araddr, 32'h0);
          chk("rst_x0", X_kk_out[0], 64'h0);
          chk("rst_p00", P_kk_out[0][0], 64'h0);
          read_en = 1'b0;
          axi_rvalid = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          aborted = 1;
          break;
        end
      end else begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rresp  = 2'b00;
      end
      arp   = axi_arvalid && axi_arready;
      wait_ar = axi_arvalid && !axi_arready;
      wa    = axi_araddr;
      wl    = axi_arlen;
      ca    = axi_araddr;
      cl    = axi_arlen;
      rp    = axi_rvalid && axi_rready;
      lastc = axi_rlast;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (arp) begin
        qa.push_back(ca);
        ql.push_back(int'(cl));
        log_a.push_back(ca);
        log_l.push_back(int'(cl));
      end
      if (rp) begin
        if (lastc) begin
          void'(qa.pop_front());
          void'(ql.pop_front());
          rb = 0;
        end else begin
          rb++;
        end
      end
      if (data_valid) begin
        done = 1;
        err_done = rd_error;
        break;
      end
    end
    if (!aborted) begin
      chk("run_reached_done", done, 1'b1);
      read_en = 1'b0;
      axi_rvalid = 1'b0;
      axi_arready = 1'b0;
      @(negedge clk);
      chk("data_valid_fall", data_valid, 1'b0);
      chk("busy_idle", busy, 1'b0);
    end
  endtask

  task automatic run4(output bit done);
    logic [31:0] qa [$];
    int ql [$];
    int rb, w;
    bit arp, rp, lastc;
    logic [31:0] ca;
    logic [7:0] cl;
    logic [63:0] v;
    rb = 0;
    done = 0;
    read_en4 = 1'b1;
    arready4 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (qa.size() > 0) begin
        for (int l = 0; l < 8; l++) begin
          w = rb * 8 + l;
          if (qa[0] == PB) v = 64'h400 + 64'(w);
          else v = (w < SD4) ? 64'h40 + 64'(w)
                             : 64'hDEAD_0000 + 64'(w);
          rdata4[l*64 +: 64] = v;
        end
        rlast4  = (rb == ql[0]);
        rvalid4 = 1'b1;
      end else begin
        rvalid4 = 1'b0;
        rlast4  = 1'b0;
      end
      arp   = arvalid4 && arready4;
      ca    = araddr4;
      cl    = arlen4;
      rp    = rvalid4 && rready4;
      lastc = rlast4;
      @(posedge clk);
      @(negedge clk);
      if (arp) begin
        qa.push_back(ca);
        ql.push_back(int'(cl));
        log4_a.push_back(ca);
        log4_l.push_back(int'(cl));
      end
      if (rp) begin
        if (lastc) begin
          void'(qa.pop_front());
          void'(ql.pop_front());
          rb = 0;
        end else begin
          rb++;
        end
      end
      if (dv4) begin
        done = 1;
        break;
      end
    end
    read_en4 = 1'b0;
    rvalid4 = 1'b0;
  endtask

  initial begin
    int cyc;
    bit err_done, d4, bx4, bp4;
    logic [63:0] exp_tmp;
    n_pass = 0;
    n_total = 0;
    n_fail = 0;
    rst_n = 1'b0;
    read_en = 1'b0;
    axi_arready = 1'b0;
    axi_rdata = '0;
    axi_rresp = 2'b00;
    axi_rlast = 1'b0;
    axi_rvalid = 1'b0;
    read_en4 = 1'b0;
    arready4 = 1'b0;
    rdata4 = '0;
    rresp4 = 2'b00;
    rlast4 = 1'b0;
    rvalid4 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);

    chk("reset_arvalid", axi_arvalid, 1'b0);
    chk("reset_rready", axi_rready, 1'b0);
    chk("reset_arlen", axi_arlen, 8'h0);
    chk("reset_arsize", axi_arsize, 3'b110);
    chk("reset_arburst", axi_arburst, 2'b01);
    chk("reset_data_valid", data_valid, 1'b0);
    chk("reset_rd_error", rd_error, 1'b0);
    check_arrays("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fill_pattern();
    log_a.delete();
    log_l.delete();
    run_read(1'b0, -1, -1, -1, cyc, err_done);
    model_load(SD*SD);
    chk("t1_ar_count", log_a.size(), 2);
    chk("t1_ar0_addr", log_a[0], XB);
    chk("t1_ar0_len", log_l[0], XBEATS - 1);
    chk("t1_ar1_addr", log_a[1], PB);
    chk("t1_ar1_len", log_l[1], PBEATS - 1);
    chk("t1_x11", X_kk_out[11], 64'h10B);
    chk("t1_p11_11", P_kk_out[11][11], 64'h108F);
    chk("t1_latency", cyc, 2 + (1 + XBEATS) + (1 + PBEATS));
    chk("t1_rd_error", err_done, 1'b0);
    check_arrays("t1");

    log_a.delete();
    log_l.delete();
    run_read(1'b1, -1, -1, -1, cyc, err_done);
    chk("t2_ar1_addr", log_a[1], PB);
    chk("t2_rd_error", err_done, 1'b0);
    check_arrays("t2");

    fill_random();
    run_read(1'b1, 5, -1, -1, cyc, err_done);
    model_load(SD*SD);
    chk("t3_err_at_done", err_done, 1'b1);
    chk("t3_err_in_idle", rd_error, 1'b1);
    check_arrays("t3");

    fill_random();
    run_read(1'b0, -1, -1, -1, cyc, err_done);
    model_load(SD*SD);
    chk("t3b_err_cleared", err_done, 1'b0);
    check_arrays("t3b");

    fill_random();
    run_read(1'b1, -1, 10, -1, cyc, err_done);
    model_load(88);
    chk("t4_err_early_last", err_done, 1'b1);
    exp_tmp = exp_p[SD*SD-1];
    chk("t4_p_last_kept", P_kk_out[SD-1][SD-1], exp_tmp);
    check_arrays("t4");

    fill_random();
    run_read(1'b0, -1, -1, 7, cyc, err_done);
    model_clear();
    chk("t5_err_after_rst", rd_error, 1'b0);
    check_arrays("t5_rst");
    fill_random();
    run_read(1'b1, -1, -1, -1, cyc, err_done);
    model_load(SD*SD);
    chk("t5_err_fresh", err_done, 1'b0);
    check_arrays("t5_fresh");

    run4(d4);
    chk("d4_done", d4, 1'b1);
    chk("d4_ar_count", log4_a.size(), 2);
    chk("d4_ar0_len", log4_l[0], 0);
    chk("d4_ar1_addr", log4_a[1], PB);
    chk("d4_ar1_len", log4_l[1], 1);
    bx4 = 0;
    bp4 = 0;
    for (int i = 0; i < SD4; i++)
      if (x4[i] !== 64'h40 + 64'(i)) bx4 = 1;
    for (int r = 0; r < SD4; r++)
      for (int c = 0; c < SD4; c++)
        if (p4[r][c] !== 64'h400 + 64'(r*SD4+c)) bp4 = 1;
    chk("d4_x_words", bx4, 1'b0);
    chk("d4_p_words", bp4, 1'b0);
    chk("d4_rd_error", err4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ddr4_state_reader.md
# ddr4_state_reader

AXI4-Full read master that loads the Kalman state vector X and covariance P from DDR4 into register arrays before a filter iteration. It sits between the DDR4 controller's AXI slave port and the filter core's X/P inputs. It is the read-side counterpart of the result writer and uses the same memory layout: 64-bit words, eight lanes per 512-bit beat, lane 0 in bits [63:0], P row-major.

## Interface
- STATE_DIM, 12, state dimension; X has STATE_DIM words, P has STATE_DIM*STATE_DIM words.
- ADDR_X_BASE, 32'h0010_0000, byte address of X in DDR4; 64-byte aligned.
- ADDR_P_BASE, 32'h0020_0000, byte address of P in DDR4; 64-byte aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- read_en  in  1  level start request; sampled in IDLE.
- X_kk_out  out  [STATE_DIM][64]  loaded state vector.
- P_kk_out  out  [STATE_DIM][STATE_DIM][64]  loaded covariance, [row][col].
- data_valid  out  1  high in DONE: X/P complete and coherent.
- busy  out  1  high in every state except IDLE and DONE.
- rd_error  out  1  sticky; cleared when a new read starts from IDLE.
- axi_araddr  out  32  burst start address.
- axi_arlen  out  8  burst length minus 1.
- axi_arsize  out  3  always 3'b110 (64 B).
- axi_arburst  out  2  always 2'b01 (INCR).
- axi_arvalid  out  1  address valid.
- axi_arready  in  1  address ready.
- axi_rdata  in  512  read data beat.
- axi_rresp  in  2  read response.
- axi_rlast  in  1  last beat of the burst.
- axi_rvalid  in  1  data valid.
- axi_rready  out  1  data ready.

## Operation
- Constants:
  - X_BEATS = ceil(STATE_DIM/8), X_ARLEN = X_BEATS-1. At the default: 2 beats, arlen 1.
  - P_BEATS = ceil(STATE_DIM²/8), P_ARLEN = P_BEATS-1. At the default: 18 beats, arlen 17.
- FSM states: IDLE, AR_X, R_X, AR_P, R_P, DONE.
- IDLE → AR_X when read_en=1. On this transition:
  - load araddr=ADDR_X_BASE, arlen=X_ARLEN, arvalid=1;
  - beat counter = 0; rd_error = 0.
- AR_X: arvalid held until arvalid&&arready. On handshake, arvalid=0, rready=1, go to R_X.
- R_X: on each rvalid&&rready (r_hs), beat b lane l writes word b*8+l into X_kk_out. Lanes with index ≥ STATE_DIM are discarded.
- R_X burst end: on the r_hs where rlast=1 or beat==X_ARLEN, set rready=0, load araddr=ADDR_P_BASE, arlen=P_ARLEN, arvalid=1, go to AR_P. Otherwise increment the beat counter.
- AR_P and R_P mirror AR_X and R_X. P lin index = b*8+l maps to row = lin/STATE_DIM, col = lin%STATE_DIM. Lanes with lin ≥ STATE_DIM² are discarded. R_P burst end → DONE.
- DONE: data_valid=1. When read_en=0, go to IDLE; data_valid falls on the same edge. The X/P arrays keep their contents.
- rd_error is set (sticky) in three cases:
  - any r_hs with rresp≠2'b00; the data is still stored;
  - rlast=1 on a beat with beat<ARLEN; the burst ends early and the FSM advances;
  - rlast=0 on beat==ARLEN; the burst ends anyway.
- rready is deasserted outside the R states. R beats arriving in IDLE/AR/DONE are not accepted.

## Timing
- Reset values: all AXI outputs 0 except arsize=3'b110 and arburst=2'b01. X_kk_out, P_kk_out, data_valid, busy and rd_error are all 0. The FSM is in IDLE.
- arvalid rises on the first clk edge after read_en is sampled high in IDLE.
- rready rises on the edge that completes the AR handshake. One R beat is accepted per cycle while rvalid=1.
- The array write and the counter update happen on the r_hs edge. Data is visible on the next cycle.
- The AR for P is issued on the same edge as the final X handshake; there is no gap cycle.
- Minimum latency from read_en high to data_valid high, with arready=rvalid=1 throughout: 2 + (1+X_BEATS) + (1+P_BEATS) cycles = 24 at the default.
- Reset asserted mid-burst clears everything immediately; no AXI cleanup is attempted.
- read_en deasserted mid-operation has no effect until DONE.

## Structure
- Shared package ddr4_axi_pkg holds:
  - LANES_PER_BEAT=8, BYTES_PER_BEAT=64;
  - AXSIZE_64B=3'b110, BURST_INCR=2'b01, RESP_OKAY=2'b00;
  - a ceil-div function for beat counts.
  The result writer uses the same package.
- The FSM state typedef is local to the module.
- No sub-module. The lane unpack is an inline loop, roughly 200 lines total.

## Test plan
- Default parameters, arready and rvalid always 1, X words 0x100+i, P words 0x1000+lin:
  - ARs are exactly (0x0010_0000, len 1) then (0x0020_0000, len 17);
  - X_kk_out[11]=0x10B and P[11][11]=0x108F;
  - data_valid rises at cycle 24; rd_error=0.
- AXI backpressure (arready random 30%, rvalid random gaps): arvalid is held stable until the handshake, and the final arrays are identical to the no-backpressure case.
- rresp=2'b10 on P beat 5: rd_error=1 and stays 1 through DONE, the data is stored, and the flow completes. A new read_en after IDLE clears rd_error.
- rlast early on P beat 10: rd_error=1, the FSM enters DONE, and P words at lin ≥ 88 keep their prior values.
- rst_n pulsed low during R_P beat 7: all outputs return to reset values immediately. A fresh read_en completes normally.
- STATE_DIM=4: arlens are 0 and 1, X upper lanes 4–7 are discarded, and P uses both beats fully.
